systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
//
// Sequencer for an N x N systolic MAC array. One matrix-multiply pass runs as:
// clear the accumulators, stream k_len operand pairs out of the A/B buffers,
// let the skewed wavefront drain through the array, capture the C results,
// then pulse done. No data passes through this block; it only produces
// strobes, buffer addresses and the per-row/per-column operand-valid skew.
//
// Parameters
//   N          array dimension (N x N cells), legal range 2..16
//   KW         width of k_len and of the operand buffer read addresses
//   DATA_WIDTH datapath width of the surrounding array (informational only)
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   start      in   1    request a pass; only looked at in IDLE
//   k_len      in   KW   inner-product length, captured when start is accepted
//   abort      in   1    cancel the pass in progress
//   busy       out  1    a pass is in progress
//   done       out  1    one-cycle pulse on normal completion
//   a_rd_en    out  1    A buffer read strobe
//   a_rd_addr  out  KW   A buffer read address
//   b_rd_en    out  1    B buffer read strobe
//   b_rd_addr  out  KW   B buffer read address
//   row_en     out  N    skewed A-operand valid, one bit per array row
//   col_en     out  N    skewed B-operand valid, one bit per array column
//   acc_clr    out  1    clear every MAC accumulator
//   c_capture  out  1    latch the array C outputs into the result buffer
// -----------------------------------------------------------------------------
module systolic_ctrl #(
  parameter int N          = 4,
  parameter int KW         = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          a_rd_en,
  output logic [KW-1:0] a_rd_addr,
  output logic          b_rd_en,
  output logic [KW-1:0] b_rd_addr,
  output logic [N-1:0]  row_en,
  output logic [N-1:0]  col_en,
  output logic          acc_clr,
  output logic          c_capture
);

  // The flush counter has to reach 2N-1. DATA_WIDTH is folded in with a zero
  // weight so the parameter stays referenced without changing anything.
  localparam int FW = $clog2(2 * N) + (DATA_WIDTH * 0);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 1);
  localparam logic [KW-1:0] K_ONE      = KW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [KW-1:0] r_kLen;
  logic [KW-1:0] r_feedCnt;
  logic [FW-1:0] r_flushCnt;
  logic [N-1:0]  r_rowEn;
  logic [N-1:0]  r_colEn;
  logic          w_abort;
  logic          w_feed;

  // Abort only means something while a pass is running; in IDLE it is inert.
  assign w_abort = abort && (r_state != S_IDLE);
  assign w_feed  = (r_state == S_FEED);

  // Next-state logic. The FEED exit compares against k_len-1 on the latched
  // length, which is never zero, so the compare cannot underflow and the
  // feed counter never has to hold the value 2^KW. Abort is applied last so
  // it overrides every other transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !abort && (k_len != '0)) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_next = S_FEED;
      end
      S_FEED: begin
        if (r_feedCnt == (r_kLen - K_ONE)) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_flushCnt == FLUSH_LAST) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_abort) begin
      w_next = S_IDLE;
    end
  end

  // State register, latched length and the two phase counters. Each counter
  // only advances while its phase continues and is zero otherwise, so a new
  // phase (or an abort) always starts it from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_kLen     <= '0;
      r_feedCnt  <= '0;
      r_flushCnt <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && (w_next == S_CLEAR)) begin
        r_kLen <= k_len;
      end
      if ((r_state == S_FEED) && (w_next == S_FEED)) begin
        r_feedCnt <= r_feedCnt + K_ONE;
      end else begin
        r_feedCnt <= '0;
      end
      if ((r_state == S_FLUSH) && (w_next == S_FLUSH)) begin
        r_flushCnt <= r_flushCnt + FW'(1);
      end else begin
        r_flushCnt <= '0;
      end
    end
  end

  // Operand-valid skew chains. Bit 0 lags the read strobe by the one-cycle
  // buffer latency and each further row/column adds one cycle, giving the
  // diagonal wavefront the array expects. An abort wipes the chains at once
  // so no stale valids leak into the next pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rowEn <= '0;
      r_colEn <= '0;
    end else if (w_abort) begin
      r_rowEn <= '0;
      r_colEn <= '0;
    end else begin
      r_rowEn <= {r_rowEn[N-2:0], w_feed};
      r_colEn <= {r_colEn[N-2:0], w_feed};
    end
  end

  // Outputs decode straight from the registered state, so they fall to zero
  // the moment reset clears the state, without waiting for a clock edge.
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign acc_clr   = (r_state == S_CLEAR);
  assign c_capture = (r_state == S_CAPTURE);
  assign a_rd_en   = w_feed;
  assign b_rd_en   = w_feed;
  assign a_rd_addr = w_feed ? r_feedCnt : '0;
  assign b_rd_addr = w_feed ? r_feedCnt : '0;
  assign row_en    = r_rowEn;
  assign col_en    = r_colEn;

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
//
// Bench for systolic_ctrl. Two instances share clock and reset: "dut" with
// N=4, KW=8 for most scenarios and "dutMax" with N=4, KW=4 for the
// maximum-length pass. Expected output vectors for every cycle of a pass are
// computed from the pass timeline (CLEAR at c1, FEED c2..k+1, FLUSH for 2N
// cycles, CAPTURE, DONE) and queued when the stimulus is driven, then popped
// and compared one per cycle at the falling edge.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start = 1'b0;
  logic [7:0] k_len = 8'd0;
  logic       abort = 1'b0;
  logic       busy, done, a_rd_en, b_rd_en, acc_clr, c_capture;
  logic [7:0] a_rd_addr, b_rd_addr;
  logic [3:0] row_en, col_en;

  logic       mStart = 1'b0;
  logic [3:0] mKLen  = 4'd0;
  logic       mAbort = 1'b0;
  logic       mBusy, mDone, mARdEn, mBRdEn, mAccClr, mCCapture;
  logic [3:0] mARdAddr, mBRdAddr;
  logic [3:0] mRowEn, mColEn;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       aEn;
    logic       bEn;
    logic [7:0] aAddr;
    logic [7:0] bAddr;
    logic [3:0] rowEn;
    logic [3:0] colEn;
    logic       accClr;
    logic       cap;
  } outs_t;

  outs_t sb[$];
  int    total = 0;
  int    bad   = 0;

  systolic_ctrl #(.N(N), .KW(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
    .row_en(row_en), .col_en(col_en),
    .acc_clr(acc_clr), .c_capture(c_capture)
  );

  systolic_ctrl #(.N(N), .KW(4), .DATA_WIDTH(32)) dutMax (
    .clk(clk), .rst(rst), .start(mStart), .k_len(mKLen), .abort(mAbort),
    .busy(mBusy), .done(mDone),
    .a_rd_en(mARdEn), .a_rd_addr(mARdAddr),
    .b_rd_en(mBRdEn), .b_rd_addr(mBRdAddr),
    .row_en(mRowEn), .col_en(mColEn),
    .acc_clr(mAccClr), .c_capture(mCCapture)
  );

  always #5 clk = ~clk;

  // Expected outputs in cycle c of a pass of length k (c=1 is the cycle after
  // the accepting edge); anything past DONE is idle.
  function automatic outs_t expAt(int k, int c);
    outs_t e;
    e = '0;
    e.busy   = (c >= 1) && (c <= k + 2 * N + 3);
    e.accClr = (c == 1);
    if (c >= 2 && c <= k + 1) begin
      e.aEn   = 1'b1;
      e.bEn   = 1'b1;
      e.aAddr = 8'(c - 2);
      e.bAddr = 8'(c - 2);
    end
    for (int i = 0; i < N; i++) begin
      if (c >= 3 + i && c <= k + 2 + i) begin
        e.rowEn[i] = 1'b1;
        e.colEn[i] = 1'b1;
      end
    end
    e.cap  = (c == k + 2 * N + 2);
    e.done = (c == k + 2 * N + 3);
    return e;
  endfunction

  function automatic outs_t obsMain();
    outs_t o;
    o = {busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
         row_en, col_en, acc_clr, c_capture};
    return o;
  endfunction

  function automatic outs_t obsMax();
    outs_t o;
    o = {mBusy, mDone, mARdEn, mBRdEn, {4'b0000, mARdAddr}, {4'b0000, mBRdAddr},
         mRowEn, mColEn, mAccClr, mCCapture};
    return o;
  endfunction

  // Outputs held at zero while reset is asserted, even with start high across
  // a clock edge. Releases reset at a falling edge and leaves start=1, k_len=3
  // so the very next rising edge is the accepting edge of the nominal pass.
  task automatic test_reset();
    outs_t o;
    @(negedge clk);
    o = obsMain();
    total++;
    if (o !== '0) begin bad++; $display("[TB] FAIL reset_main got=%h exp=0", o); end
    o = obsMax();
    total++;
    if (o !== '0) begin bad++; $display("[TB] FAIL reset_max got=%h exp=0", o); end
    start = 1'b1;
    k_len = 8'd3;
    @(negedge clk);
    o = obsMain();
    total++;
    if (o !== '0) begin bad++; $display("[TB] FAIL reset_start got=%h exp=0", o); end
    rst = 1'b0;
  endtask

  // Nominal k_len=3 pass; k_len is changed right after acceptance and must
  // not disturb the pass.
  task automatic test_nominal();
    outs_t e, o;
    start = 1'b1;
    k_len = 8'd3;
    for (int c = 1; c <= 16; c++) sb.push_back(expAt(3, c));
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; k_len = 8'd7; end
      e = sb.pop_front();
      o = obsMain();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL nominal c%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  // start with k_len=0 held for 20 cycles must never leave IDLE.
  task automatic test_zero_len();
    outs_t e, o;
    start = 1'b1;
    k_len = 8'd0;
    for (int c = 1; c <= 20; c++) sb.push_back('0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 20) start = 1'b0;
      e = sb.pop_front();
      o = obsMain();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL zero_len c%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  // A start pulsed mid-pass is neither obeyed nor queued.
  task automatic test_restart_ignored();
    outs_t e, o;
    start = 1'b1;
    k_len = 8'd3;
    for (int c = 1; c <= 20; c++) sb.push_back(expAt(3, c));
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) begin start = 1'b1; k_len = 8'd5; end
      if (c == 6) start = 1'b0;
      e = sb.pop_front();
      o = obsMain();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL restart_ign c%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  // Abort at c3 of a k_len=10 pass, fresh pass from c5, then start and abort
  // together in IDLE.
  task automatic test_abort();
    outs_t e, o;
    start = 1'b1;
    k_len = 8'd10;
    for (int c = 1; c <= 3; c++) sb.push_back(expAt(10, c));
    sb.push_back('0);
    sb.push_back('0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 4) abort = 1'b0;
      e = sb.pop_front();
      o = obsMain();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL abort c%0d got=%h exp=%h", c, o, e); end
      if (c == 3) abort = 1'b1;
    end
    start = 1'b1;
    k_len = 8'd3;
    for (int c = 1; c <= 16; c++) sb.push_back(expAt(3, c));
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = sb.pop_front();
      o = obsMain();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL after_abort c%0d got=%h exp=%h", c, o, e); end
    end
    start = 1'b1;
    abort = 1'b1;
    for (int c = 1; c <= 3; c++) sb.push_back('0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; abort = 1'b0; end
      e = sb.pop_front();
      o = obsMain();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL start_abort c%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  // Longest pass on the KW=4 instance: addresses 0..14, done at c26.
  task automatic test_max_len();
    outs_t e, o;
    mStart = 1'b1;
    mKLen  = 4'd15;
    for (int c = 1; c <= 28; c++) sb.push_back(expAt(15, c));
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (c == 1) mStart = 1'b0;
      e = sb.pop_front();
      o = obsMax();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL max_len c%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  // Reset raised between edges during FEED must clear outputs without a clock
  // edge; after release a start gives a nominal pass.
  task automatic test_async_reset();
    outs_t e, o;
    start = 1'b1;
    k_len = 8'd3;
    for (int c = 1; c <= 3; c++) sb.push_back(expAt(3, c));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = sb.pop_front();
      o = obsMain();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL pre_rst c%0d got=%h exp=%h", c, o, e); end
    end
    #2 rst = 1'b1;
    #1;
    o = obsMain();
    total++;
    if (o !== '0) begin bad++; $display("[TB] FAIL async_rst got=%h exp=0", o); end
    @(negedge clk);
    o = obsMain();
    total++;
    if (o !== '0) begin bad++; $display("[TB] FAIL rst_hold got=%h exp=0", o); end
    rst   = 1'b0;
    start = 1'b1;
    k_len = 8'd3;
    for (int c = 1; c <= 16; c++) sb.push_back(expAt(3, c));
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = sb.pop_front();
      o = obsMain();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL post_rst c%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  // start held high: three k_len=2 passes of 2+2N+4=14 cycles each, one done
  // per pass, then nothing once start drops.
  task automatic test_back_to_back();
    outs_t e, o;
    int    doneCnt;
    doneCnt = 0;
    start = 1'b1;
    k_len = 8'd2;
    for (int p = 0; p < 3; p++) begin
      for (int c = 1; c <= 14; c++) sb.push_back(expAt(2, c));
    end
    sb.push_back('0);
    sb.push_back('0);
    for (int n = 1; n <= 44; n++) begin
      @(negedge clk);
      if (n == 42) start = 1'b0;
      e = sb.pop_front();
      o = obsMain();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL b2b n%0d got=%h exp=%h", n, o, e); end
      if (done) doneCnt++;
    end
    total++;
    if (doneCnt !== 3) begin bad++; $display("[TB] FAIL b2b_done_count got=%0d exp=3", doneCnt); end
  endtask

  initial begin
    $display("[TB] starting systolic_ctrl bench");
    test_reset();
    test_nominal();
    test_zero_len();
    test_restart_ignored();
    test_abort();
    test_max_len();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
